// File: rtl/wb_ic_pkg.sv
// ---------------------------------------------------------------------------
// wb_ic_pkg
// Shared definitions for the round-robin Wishbone shared-bus interconnect.
//  - MAX_NM / MAX_NS : largest supported master / slave counts
//  - PTR_W           : width of a master index (round-robin pointer)
//  - bus_state_t     : interconnect FSM state encoding
//  - onehot_first()  : one-hot pick of the first requester at or after ptr,
//                      searching cyclically over the n populated masters
// ---------------------------------------------------------------------------
package wb_ic_pkg;

    localparam int MAX_NM = 8;
    localparam int MAX_NS = 16;
    localparam int PTR_W  = $clog2(MAX_NM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } bus_state_t;

    // Cyclic first-set search. Only the lowest n request bits are
    // considered, so the wrap happens at n rather than at MAX_NM.
    function automatic logic [MAX_NM-1:0] onehot_first(
        input logic [MAX_NM-1:0] req,
        input logic [PTR_W-1:0]  ptr,
        input int unsigned       n
    );
        logic [MAX_NM-1:0] oh;
        logic              found;
        logic [PTR_W-1:0]  idx;
        oh    = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_NM; i++) begin
            idx = PTR_W'((32'(ptr) + i) % n);
            if ((i < n) && !found && req[idx]) begin
                oh[idx] = 1'b1;
                found   = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
// Round-robin arbiter with a registered one-hot grant.
// Ports:
//  clk        in   clock
//  rst_n      in   asynchronous active-low reset
//  req        in   NM request lines (master cyc)
//  grant_en   in   bus is idle: latch a new grant this edge if anyone asks
//  release_en in   current owner dropped cyc: clear grant, advance pointer
//  gnt        out  NM registered one-hot (or zero) grant
// ---------------------------------------------------------------------------
module wb_rr_arbiter
    import wb_ic_pkg::*;
#(
    parameter int NM = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [NM-1:0] req,
    input  logic          grant_en,
    input  logic          release_en,
    output logic [NM-1:0] gnt
);

    logic [MAX_NM-1:0] req_ext;
    logic [MAX_NM-1:0] first_oh;
    logic [MAX_NM-1:0] gnt_reg;
    logic [PTR_W-1:0]  ptr_reg;
    logic [PTR_W-1:0]  cur_idx;
    logic [PTR_W-1:0]  ptr_next;

    // Widen the request vector to the package maximum; unpopulated lines
    // are tied low so the cyclic search never selects them.
    for (genvar gi = 0; gi < MAX_NM; gi++) begin : g_req
        if (gi < NM) begin : g_live
            assign req_ext[gi] = req[gi];
        end else begin : g_tie
            assign req_ext[gi] = 1'b0;
        end
    end

    assign first_oh = onehot_first(req_ext, ptr_reg, NM);

    // Pointer moves to the master just after the one releasing the bus.
    always_comb begin
        cur_idx = '0;
        for (int i = 0; i < MAX_NM; i++) begin
            if (gnt_reg[i]) begin
                cur_idx = PTR_W'(i);
            end
        end
        ptr_next = (cur_idx == PTR_W'(NM - 1)) ? '0 : cur_idx + PTR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_reg <= '0;
            ptr_reg <= '0;
        end else if (release_en) begin
            gnt_reg <= '0;
            ptr_reg <= ptr_next;
        end else if (grant_en) begin
            gnt_reg <= first_oh;
        end
    end

    for (genvar gi = 0; gi < NM; gi++) begin : g_gnt
        assign gnt[gi] = gnt_reg[gi];
    end

endmodule

// File: rtl/wb_rr_conbus.sv
// ---------------------------------------------------------------------------
// wb_rr_conbus
// Shared-bus Wishbone interconnect: NM masters, NS slaves, one transfer at a
// time. Round-robin registered grant, base/mask slave decode, error on
// unmapped addresses and a per-transfer watchdog that forces err.
// Ports:
//  clk_i, rst_n_i                 clock, asynchronous active-low reset
//  m_adr_i/m_dat_i/m_sel_i/m_we_i packed master request fields
//  m_cyc_i, m_stb_i               per-master cycle / strobe
//  m_dat_o                        read data broadcast to all masters
//  m_ack_o, m_err_o, m_rty_o      per-master responses (granted master only)
//  s_adr_o/s_dat_o/s_sel_o/s_we_o request fields broadcast to all slaves
//  s_cyc_o, s_stb_o               per-slave cycle / strobe, one-hot or zero
//  s_dat_i, s_ack_i, s_err_i, s_rty_i  slave read data and responses
//  gnt_o                          current grant, one-hot or zero
// ---------------------------------------------------------------------------
module wb_rr_conbus
    import wb_ic_pkg::*;
#(
    parameter int               NM      = 2,
    parameter int               NS      = 4,
    parameter int               AW      = 32,
    parameter int               DW      = 32,
    parameter logic [NS*AW-1:0] S_BASE  = '0,
    parameter logic [NS*AW-1:0] S_MASK  = '0,
    parameter int               TIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NM*AW-1:0]     m_adr_i,
    input  logic [NM*DW-1:0]     m_dat_i,
    input  logic [NM*DW/8-1:0]   m_sel_i,
    input  logic [NM-1:0]        m_we_i,
    input  logic [NM-1:0]        m_cyc_i,
    input  logic [NM-1:0]        m_stb_i,
    output logic [DW-1:0]        m_dat_o,
    output logic [NM-1:0]        m_ack_o,
    output logic [NM-1:0]        m_err_o,
    output logic [NM-1:0]        m_rty_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [DW-1:0]        s_dat_o,
    output logic [DW/8-1:0]      s_sel_o,
    output logic                 s_we_o,
    output logic [NS-1:0]        s_cyc_o,
    output logic [NS-1:0]        s_stb_o,
    input  logic [NS*DW-1:0]     s_dat_i,
    input  logic [NS-1:0]        s_ack_i,
    input  logic [NS-1:0]        s_err_i,
    input  logic [NS-1:0]        s_rty_i,
    output logic [NM-1:0]        gnt_o
);

    localparam int SELW = DW / 8;
    // Counter only ever holds 0..TIMEOUT-1.
    localparam int CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    bus_state_t      state_reg;
    logic [CW-1:0]   cnt_reg;
    logic            err_pulse_reg;  // registered err, one cycle
    logic            err_sent_reg;   // err already given for the current stb

    logic [NM-1:0]   gnt;
    logic            grant_en;
    logic            release_en;

    logic [AW-1:0]   g_adr;
    logic [DW-1:0]   g_dat;
    logic [SELW-1:0] g_sel;
    logic            g_we;
    logic            g_cyc;
    logic            g_stb;

    logic [NS-1:0]   hit;
    logic [NS-1:0]   sel_oh;
    logic            any_hit;
    logic            active;
    logic [DW-1:0]   rdat;
    logic            ack_sel;
    logic            err_sel;
    logic            rty_sel;
    logic            resp;
    logic            counting;
    logic            expire;
    logic            miss_err;

    // ---------------- arbitration ----------------
    assign grant_en   = (state_reg == IDLE);
    assign release_en = (state_reg == BUSY) && !g_cyc;

    wb_rr_arbiter #(.NM(NM)) u_arb (
        .clk        (clk_i),
        .rst_n      (rst_n_i),
        .req        (m_cyc_i),
        .grant_en   (grant_en),
        .release_en (release_en),
        .gnt        (gnt)
    );

    assign gnt_o = gnt;

    // ---------------- master -> bus mux (AND-OR on one-hot grant) ------
    always_comb begin
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        g_we  = 1'b0;
        g_cyc = 1'b0;
        g_stb = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (gnt[i]) begin
                g_adr |= m_adr_i[i*AW +: AW];
                g_dat |= m_dat_i[i*DW +: DW];
                g_sel |= m_sel_i[i*SELW +: SELW];
                g_we  |= m_we_i[i];
                g_cyc |= m_cyc_i[i];
                g_stb |= m_stb_i[i];
            end
        end
    end

    assign s_adr_o = g_adr;
    assign s_dat_o = g_dat;
    assign s_sel_o = g_sel;
    assign s_we_o  = g_we;

    // ---------------- address decode ----------------
    for (genvar gi = 0; gi < NS; gi++) begin : g_dec
        localparam logic [AW-1:0] BASE_K = S_BASE[gi*AW +: AW];
        localparam logic [AW-1:0] MASK_K = S_MASK[gi*AW +: AW];
        assign hit[gi] = ((g_adr & MASK_K) == (BASE_K & MASK_K));
    end

    // Isolate the lowest set bit: overlapping windows go to the lowest index.
    assign sel_oh  = hit & (~hit + NS'(1));
    assign any_hit = |hit;

    // Grant is live only while in BUSY and the owner still holds cyc; ERR
    // and the release cycle keep the slaves quiet.
    assign active  = (state_reg == BUSY) && g_cyc;
    assign s_cyc_o = sel_oh & {NS{active}};
    // Once err has been returned for this stb the slave is not strobed
    // again until the master drops stb.
    assign s_stb_o = s_cyc_o & {NS{g_stb && !err_sent_reg}};

    // ---------------- slave -> master response routing ----------------
    always_comb begin
        rdat = '0;
        for (int k = 0; k < NS; k++) begin
            if (sel_oh[k]) begin
                rdat |= s_dat_i[k*DW +: DW];
            end
        end
    end

    assign m_dat_o = active ? rdat : '0;
    assign ack_sel = |(s_stb_o & s_ack_i);
    assign err_sel = |(s_stb_o & s_err_i);
    assign rty_sel = |(s_stb_o & s_rty_i);
    assign resp    = ack_sel || err_sel || rty_sel;

    assign m_ack_o = gnt & {NM{ack_sel}};
    assign m_err_o = gnt & {NM{err_sel || err_pulse_reg}};
    assign m_rty_o = gnt & {NM{rty_sel}};

    // ---------------- watchdog / decode-miss ----------------
    assign counting = (|s_stb_o) && !resp;
    // A response in the expiry cycle suppresses expire, so it wins.
    assign expire   = (TIMEOUT != 0) && counting && (cnt_reg == CW'(TIMEOUT - 1));
    assign miss_err = active && g_stb && !any_hit && !err_sent_reg;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            err_pulse_reg <= 1'b0;
            err_sent_reg  <= 1'b0;
        end else begin
            err_pulse_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg      <= '0;
                    err_sent_reg <= 1'b0;
                    if (|m_cyc_i) begin
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (!g_cyc) begin
                        state_reg    <= IDLE;
                        cnt_reg      <= '0;
                        err_sent_reg <= 1'b0;
                    end else if (expire) begin
                        state_reg     <= ERR;
                        cnt_reg       <= '0;
                        err_pulse_reg <= 1'b1;
                        err_sent_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= counting ? cnt_reg + CW'(1) : '0;
                        if (miss_err) begin
                            err_pulse_reg <= 1'b1;
                            err_sent_reg  <= 1'b1;
                        end else if (!g_stb) begin
                            err_sent_reg <= 1'b0;
                        end
                    end
                end
                ERR: begin
                    state_reg <= BUSY;
                    cnt_reg   <= '0;
                    if (!g_stb) begin
                        err_sent_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_rr_conbus.sv
// ---------------------------------------------------------------------------
// tb_wb_rr_conbus
// Directed bench for wb_rr_conbus: 3 masters, 2 slaves, TIMEOUT=4.
//  slave0 window 0x40000000 / mask 0xE0000000
//  slave1 window 0x80000000 / mask 0xF0000000
// Inputs change 1 time unit after the rising edge, outputs are sampled a
// further 1-2 units later, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_wb_rr_conbus;

    localparam int NM = 3;
    localparam int NS = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
    localparam logic [NS*AW-1:0] BASES = {32'h8000_0000, 32'h4000_0000};
    localparam logic [NS*AW-1:0] MASKS = {32'hF000_0000, 32'hE000_0000};

    logic                clk;
    logic                rst_n;
    logic [NM*AW-1:0]    m_adr;
    logic [NM*DW-1:0]    m_wdat;
    logic [NM*DW/8-1:0]  m_sel;
    logic [NM-1:0]       m_we, m_cyc, m_stb;
    logic [DW-1:0]       m_rdat;
    logic [NM-1:0]       m_ack, m_err, m_rty;
    logic [AW-1:0]       s_adr;
    logic [DW-1:0]       s_wdat;
    logic [DW/8-1:0]     s_sel;
    logic                s_we;
    logic [NS-1:0]       s_cyc, s_stb;
    logic [NS*DW-1:0]    s_rdat;
    logic [NS-1:0]       s_ack, s_err, s_rty;
    logic [NM-1:0]       gnt;

    int n_checks = 0;
    int n_fail   = 0;

    wb_rr_conbus #(
        .NM(NM), .NS(NS), .AW(AW), .DW(DW),
        .S_BASE(BASES), .S_MASK(MASKS), .TIMEOUT(TO)
    ) dut (
        .clk_i   (clk),    .rst_n_i (rst_n),
        .m_adr_i (m_adr),  .m_dat_i (m_wdat), .m_sel_i (m_sel),
        .m_we_i  (m_we),   .m_cyc_i (m_cyc),  .m_stb_i (m_stb),
        .m_dat_o (m_rdat), .m_ack_o (m_ack),  .m_err_o (m_err), .m_rty_o (m_rty),
        .s_adr_o (s_adr),  .s_dat_o (s_wdat), .s_sel_o (s_sel), .s_we_o  (s_we),
        .s_cyc_o (s_cyc),  .s_stb_o (s_stb),
        .s_dat_i (s_rdat), .s_ack_i (s_ack),  .s_err_i (s_err), .s_rty_i (s_rty),
        .gnt_o   (gnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %-22s got=%0h expected=%0h", tag, act, exp);
        end else begin
            $display("ok   %-22s value=%0h", tag, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic c, input logic s,
                         input logic [31:0] a, input logic w, input logic [31:0] d);
        m_cyc[i]            = c;
        m_stb[i]            = s;
        m_adr[i*AW +: AW]   = a;
        m_we[i]             = w;
        m_wdat[i*DW +: DW]  = d;
        m_sel[i*4 +: 4]     = 4'hF;
    endtask

    task automatic all_idle();
        m_cyc = '0;
        m_stb = '0;
        s_ack = '0;
        s_err = '0;
        s_rty = '0;
    endtask

    logic [NM-1:0] drop_n, rise_n, prev_gnt;
    logic [NM-1:0] seq [4];
    int            gap [4];
    int            idle_cnt, ngr, beats, nstb;
    logic          m0_seen;

    initial begin
        rst_n  = 1'b0;
        m_adr  = '0;
        m_wdat = '0;
        m_sel  = '0;
        m_we   = '0;
        all_idle();
        s_rdat = {32'h5555_AAAA, 32'hCAFE_F00D};

        // ---------------- reset state ----------------
        #2;
        check_eq("rst_gnt",   64'(gnt),   64'h0);
        check_eq("rst_s_cyc", 64'(s_cyc), 64'h0);
        check_eq("rst_m_ack", 64'(m_ack), 64'h0);
        check_eq("rst_s_adr", 64'(s_adr), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ---------------- round-robin m0,m1,m2,m0 ----------------
        set_m(0, 1, 1, 32'h4000_0000, 0, 0);
        set_m(1, 1, 1, 32'h8000_0010, 0, 0);
        set_m(2, 1, 1, 32'h4000_0020, 0, 0);
        drop_n = '0; rise_n = '0; prev_gnt = '0; idle_cnt = 0; ngr = 0;
        for (int n = 0; n < 60 && ngr < 4; n++) begin
            step();
            for (int i = 0; i < NM; i++) begin
                if (drop_n[i]) begin
                    m_cyc[i] = 1'b0; m_stb[i] = 1'b0; drop_n[i] = 1'b0; rise_n[i] = 1'b1;
                end else if (rise_n[i]) begin
                    m_cyc[i] = 1'b1; m_stb[i] = 1'b1; rise_n[i] = 1'b0;
                end
            end
            #1;
            s_ack = s_stb;
            #1;
            if (gnt == '0) begin
                idle_cnt++;
            end else if (prev_gnt == '0) begin
                seq[ngr] = gnt;
                gap[ngr] = idle_cnt;
                ngr++;
                idle_cnt = 0;
            end
            prev_gnt = gnt;
            drop_n |= m_ack;
        end
        check_eq("rr_grants", 64'(ngr), 64'd4);
        check_eq("rr_g0", 64'(seq[0]), 64'b001);
        check_eq("rr_g1", 64'(seq[1]), 64'b010);
        check_eq("rr_g2", 64'(seq[2]), 64'b100);
        check_eq("rr_g3", 64'(seq[3]), 64'b001);
        check_eq("rr_gap1", 64'(gap[1]), 64'd1);
        check_eq("rr_gap2", 64'(gap[2]), 64'd1);
        check_eq("rr_gap3", 64'(gap[3]), 64'd1);
        step();
        all_idle();
        step();
        step();

        // ---------------- lock: m1 8 beats, m0 waits ----------------
        set_m(0, 1, 1, 32'h4000_0000, 0, 0);
        set_m(1, 1, 1, 32'h8000_0000, 0, 0);
        beats = 0; m0_seen = 1'b0;
        for (int n = 0; n < 20 && beats < 8; n++) begin
            step();
            m_adr[1*AW +: AW] = 32'h8000_0000 + 32'(beats * 4);
            #1;
            s_ack = s_stb;
            #1;
            if (n == 0) begin
                check_eq("lock_s_stb", 64'(s_stb), 64'b10);
                check_eq("lock_rdat", 64'(m_rdat), 64'h5555_AAAA);
            end
            if (gnt[0]) m0_seen = 1'b1;
            if (m_ack[1]) beats++;
        end
        check_eq("lock_beats", 64'(beats), 64'd8);
        check_eq("lock_m0_held_off", 64'(m0_seen), 64'd0);
        step();
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; s_ack = '0;
        #1;
        check_eq("lock_rel_ack", 64'(m_ack), 64'h0);
        step();
        check_eq("lock_idle_gnt", 64'(gnt), 64'h0);
        step();
        check_eq("lock_m0_gnt", 64'(gnt), 64'b001);
        s_ack = s_stb;
        #1;
        check_eq("lock_m0_ack", 64'(m_ack), 64'b001);
        step();
        all_idle();
        step();
        step();

        // ---------------- decode hit then unmapped ----------------
        set_m(0, 1, 1, 32'h4000_1234, 1, 32'h1122_3344);
        step();
        check_eq("dec_s_stb", 64'(s_stb), 64'b01);
        check_eq("dec_s_adr", 64'(s_adr), 64'h4000_1234);
        check_eq("dec_s_wdat", 64'(s_wdat), 64'h1122_3344);
        check_eq("dec_s_we", 64'(s_we), 64'd1);
        check_eq("dec_s_sel", 64'(s_sel), 64'hF);
        s_ack[0] = 1'b1;
        #1;
        check_eq("dec_m_ack", 64'(m_ack), 64'b001);
        check_eq("dec_m_rdat", 64'(m_rdat), 64'hCAFE_F00D);
        step();
        m_adr[0 +: AW] = 32'hF000_0000;
        s_ack = '0;
        #1;
        check_eq("miss_s_stb", 64'(s_stb), 64'b00);
        check_eq("miss_s_cyc", 64'(s_cyc), 64'b00);
        check_eq("miss_err_early", 64'(m_err), 64'b000);
        step();
        check_eq("miss_err_pulse", 64'(m_err), 64'b001);
        step();
        check_eq("miss_err_once", 64'(m_err), 64'b000);
        all_idle();
        step();
        step();

        // ---------------- timeout ----------------
        set_m(0, 1, 1, 32'h4000_0000, 0, 0);
        nstb = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            #1;
            if (s_stb[0]) nstb++;
            else break;
        end
        check_eq("to_stb_cycles", 64'(nstb), 64'd4);
        check_eq("to_err_pulse", 64'(m_err), 64'b001);
        check_eq("to_err_s_cyc", 64'(s_cyc), 64'b00);
        m_stb[0] = 1'b0;
        step();
        check_eq("to_err_once", 64'(m_err), 64'b000);
        set_m(0, 1, 1, 32'h4000_0008, 0, 0);
        #1;
        check_eq("to_retry_s_stb", 64'(s_stb), 64'b01);
        s_ack[0] = 1'b1;
        #1;
        check_eq("to_retry_ack", 64'(m_ack), 64'b001);
        check_eq("to_retry_err", 64'(m_err), 64'b000);
        step();
        all_idle();
        step();
        step();

        // ---------------- ack on the expiry cycle ----------------
        set_m(0, 1, 1, 32'h4000_0000, 0, 0);
        step();
        step();
        step();
        step();
        s_ack[0] = 1'b1;
        #1;
        check_eq("col_ack", 64'(m_ack), 64'b001);
        check_eq("col_err", 64'(m_err), 64'b000);
        step();
        s_ack = '0;
        #1;
        check_eq("col_err_next", 64'(m_err), 64'b000);
        check_eq("col_still_busy", 64'(s_stb), 64'b01);
        all_idle();
        step();
        step();

        // ---------------- reset mid-transfer ----------------
        set_m(0, 1, 1, 32'h4000_1234, 0, 0);
        step();
        check_eq("mid_gnt", 64'(gnt), 64'b001);
        s_ack[0] = 1'b1;
        #1;
        check_eq("mid_ack", 64'(m_ack), 64'b001);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_s_cyc", 64'(s_cyc), 64'b00);
        check_eq("mid_rst_s_stb", 64'(s_stb), 64'b00);
        check_eq("mid_rst_gnt", 64'(gnt), 64'b000);
        check_eq("mid_rst_ack", 64'(m_ack), 64'b000);
        all_idle();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("post_rst_gnt", 64'(gnt), 64'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
